// File: rtl/pet_need_engine_if.sv
// rtl/pet_need_engine_if.sv - control/status bundle between the behaviour FSM and the need-level engine
interface pet_need_engine_if #(
    parameter int CHANNELS = 3,
    parameter int LEVEL_W  = 3,
    parameter int PER_W    = 16,
    parameter int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic [CHANNELS*PER_W-1:0]   decay_period;
    logic [CHANNELS-1:0]         recover_en;
    logic [CHANNELS-1:0]         bump;
    logic                        load_en;
    logic [CHANNELS*LEVEL_W-1:0] load_level;
    logic                        freeze;
    logic                        revive;
    logic [CHANNELS*LEVEL_W-1:0] level;
    logic [CHANNELS-1:0]         low;
    logic [CHANNELS-1:0]         empty;
    logic [2:0]                  mood;
    logic [IDX_W-1:0]            need_idx;
    logic                        tick;

    modport master (
        output decay_period, recover_en, bump, load_en, load_level, freeze, revive,
        input  level, low, empty, mood, need_idx, tick
    );

    modport slave (
        input  decay_period, recover_en, bump, load_en, load_level, freeze, revive,
        output level, low, empty, mood, need_idx, tick
    );
endinterface

// File: rtl/pet_need_engine.sv
// rtl/pet_need_engine.sv - per-channel need levels with programmable decay/recovery and registered mood
module pet_need_engine #(
    parameter int CHANNELS   = 3,
    parameter int LEVEL_W    = 3,
    parameter int LEVEL_MAX  = 5,
    parameter int LOW_THRESH = 2,
    parameter int TICK_DIV   = 50000,
    parameter int PER_W      = 16,
    parameter int IDX_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    pet_need_engine_if.slave   bus
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] LVL_LOW  = LEVEL_W'(LOW_THRESH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        NEUTRAL = 3'd1,
        NEEDY   = 3'd2,
        SAD     = 3'd3,
        DEATH   = 3'd4
    } mood_t;

    logic [CNT_W-1:0]   cnt_q;
    logic               tick;
    logic [LEVEL_W-1:0] lvl_q [CHANNELS];
    logic [LEVEL_W-1:0] lvl_d [CHANNELS];
    logic [PER_W-1:0]   tmr_q [CHANNELS];
    logic [PER_W-1:0]   tmr_d [CHANNELS];
    logic [PER_W-1:0]   per   [CHANNELS];
    logic [CHANNELS-1:0] step;
    logic [CHANNELS-1:0] low;
    logic [CHANNELS-1:0] empty;
    logic [IDX_W-1:0]   need_idx;
    logic               all_full;
    int                 n_low;
    mood_t              mood_q;
    mood_t              mood_d;
    logic               reload_q;
    logic               dead;

    function automatic logic [LEVEL_W-1:0] sat_inc(input logic [LEVEL_W-1:0] v);
        return (v >= LVL_MAX) ? LVL_MAX : v + LEVEL_W'(1);
    endfunction

    function automatic logic [LEVEL_W-1:0] sat_dec(input logic [LEVEL_W-1:0] v);
        return (v == '0) ? '0 : v - LEVEL_W'(1);
    endfunction

    assign tick = (cnt_q == CNT_LAST);
    assign dead = (mood_q == DEATH);

    always_comb begin : chan_next
        step = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            per[i]   = bus.decay_period[i*PER_W +: PER_W];
            lvl_d[i] = lvl_q[i];
            tmr_d[i] = tmr_q[i];
            if (bus.revive) begin
                lvl_d[i] = LVL_MAX;
                tmr_d[i] = '0;
            end else if (bus.load_en) begin
                lvl_d[i] = (bus.load_level[i*LEVEL_W +: LEVEL_W] > LVL_MAX) ?
                           LVL_MAX : bus.load_level[i*LEVEL_W +: LEVEL_W];
                tmr_d[i] = '0;
            end else if (!dead) begin
                // >= rather than == so a shortened period takes effect on the very next tick
                if (per[i] == '0) begin
                    tmr_d[i] = '0;
                end else if (tick && !bus.freeze) begin
                    if (tmr_q[i] >= per[i] - PER_W'(1)) begin
                        step[i]  = 1'b1;
                        tmr_d[i] = '0;
                    end else begin
                        tmr_d[i] = tmr_q[i] + PER_W'(1);
                    end
                end
                if (bus.bump[i]) begin
                    lvl_d[i] = sat_inc(lvl_q[i]);
                end else if (step[i]) begin
                    lvl_d[i] = bus.recover_en[i] ? sat_inc(lvl_q[i]) : sat_dec(lvl_q[i]);
                end
            end
        end
    end

    always_comb begin : decode
        low      = '0;
        empty    = '0;
        need_idx = '0;
        all_full = 1'b1;
        n_low    = 0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            low[i]   = (lvl_q[i] <= LVL_LOW);
            empty[i] = (lvl_q[i] == '0);
            if (lvl_q[i] != LVL_MAX) all_full = 1'b0;
            if (low[i]) begin
                need_idx = IDX_W'(i);
                n_low    = n_low + 1;
            end
        end
    end

    // DEATH only re-decodes once the refilled/loaded levels have landed in the registers
    always_comb begin : mood_next
        mood_d = NEUTRAL;
        if (dead && !reload_q) mood_d = DEATH;
        else if (|empty)       mood_d = DEATH;
        else if (n_low >= 2)   mood_d = SAD;
        else if (n_low == 1)   mood_d = NEEDY;
        else if (all_full)     mood_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            mood_q   <= IDLE;
            reload_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                lvl_q[i] <= LVL_MAX;
                tmr_q[i] <= '0;
            end
        end else begin
            cnt_q    <= tick ? '0 : cnt_q + CNT_W'(1);
            mood_q   <= mood_d;
            reload_q <= bus.revive | bus.load_en;
            for (int i = 0; i < CHANNELS; i++) begin
                lvl_q[i] <= lvl_d[i];
                tmr_q[i] <= tmr_d[i];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_level
        assign bus.level[g*LEVEL_W +: LEVEL_W] = lvl_q[g];
    end

    assign bus.low      = low;
    assign bus.empty    = empty;
    assign bus.need_idx = need_idx;
    assign bus.mood     = mood_q;
    assign bus.tick     = tick;
endmodule

// File: tb/tb_pet_need_engine.sv
// tb/tb_pet_need_engine.sv - self-checking bench for pet_need_engine
module tb_pet_need_engine;
    localparam int CH = 3, LW = 3, LMAX = 5, LTH = 2, TD = 4, PW = 16, IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pet_need_engine_if #(.CHANNELS(CH), .LEVEL_W(LW), .PER_W(PW), .IDX_W(IW)) bus ();

    pet_need_engine #(
        .CHANNELS(CH), .LEVEL_W(LW), .LEVEL_MAX(LMAX), .LOW_THRESH(LTH),
        .TICK_DIV(TD), .PER_W(PW), .IDX_W(IW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: levels as integers, timers in ticks, mood from last cycle's levels
    int m_lvl[CH] = '{LMAX, LMAX, LMAX};
    int m_t[CH]   = '{0, 0, 0};
    int m_cnt     = 0;
    int m_mood    = 0;
    bit m_rl      = 1'b0;
    int nl[CH];
    int nm, p, ld;
    bit tk, dead, fire;

    function automatic int mood_of(input int lv[CH]);
        int nlow = 0;
        bit anye = 1'b0, full = 1'b1;
        for (int i = 0; i < CH; i++) begin
            if (lv[i] <= LTH) nlow++;
            if (lv[i] == 0) anye = 1'b1;
            if (lv[i] != LMAX) full = 1'b0;
        end
        if (anye) return 4;
        if (nlow >= 2) return 3;
        if (nlow == 1) return 2;
        if (full) return 0;
        return 1;
    endfunction

    function automatic int low_of(input int lv[CH]);
        int r = 0;
        for (int i = 0; i < CH; i++) if (lv[i] <= LTH) r |= (1 << i);
        return r;
    endfunction

    function automatic int empty_of(input int lv[CH]);
        int r = 0;
        for (int i = 0; i < CH; i++) if (lv[i] == 0) r |= (1 << i);
        return r;
    endfunction

    function automatic int idx_of(input int lv[CH]);
        for (int i = 0; i < CH; i++) if (lv[i] <= LTH) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CH; i++) begin
                m_lvl[i] = LMAX;
                m_t[i]   = 0;
            end
            m_cnt  = 0;
            m_mood = 0;
            m_rl   = 1'b0;
        end else begin
            tk   = (m_cnt == TD - 1);
            dead = (m_mood == 4);
            nm   = (dead && !m_rl) ? 4 : mood_of(m_lvl);
            for (int i = 0; i < CH; i++) begin
                p  = int'(bus.decay_period[i*PW +: PW]);
                ld = int'(bus.load_level[i*LW +: LW]);
                nl[i] = m_lvl[i];
                if (bus.revive) begin
                    nl[i] = LMAX;
                    m_t[i] = 0;
                end else if (bus.load_en) begin
                    nl[i] = (ld > LMAX) ? LMAX : ld;
                    m_t[i] = 0;
                end else if (!dead) begin
                    fire = 1'b0;
                    if (p == 0) m_t[i] = 0;
                    else if (tk && !bus.freeze) begin
                        if (m_t[i] >= p - 1) begin
                            fire   = 1'b1;
                            m_t[i] = 0;
                        end else begin
                            m_t[i] = m_t[i] + 1;
                        end
                    end
                    if (bus.bump[i]) nl[i] = (m_lvl[i] + 1 > LMAX) ? LMAX : m_lvl[i] + 1;
                    else if (fire && bus.recover_en[i]) nl[i] = (m_lvl[i] + 1 > LMAX) ? LMAX : m_lvl[i] + 1;
                    else if (fire) nl[i] = (m_lvl[i] == 0) ? 0 : m_lvl[i] - 1;
                end
            end
            m_lvl  = nl;
            m_mood = nm;
            m_rl   = bus.revive | bus.load_en;
            m_cnt  = tk ? 0 : m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < CH; i++)
            chk($sformatf("model_level%0d", i), int'(bus.level[i*LW +: LW]), m_lvl[i]);
        chk("model_low", int'(bus.low), low_of(m_lvl));
        chk("model_empty", int'(bus.empty), empty_of(m_lvl));
        chk("model_need_idx", int'(bus.need_idx), idx_of(m_lvl));
        chk("model_mood", int'(bus.mood), m_mood);
        chk("model_tick", int'(bus.tick), (m_cnt == TD - 1) ? 1 : 0);
    end

    task automatic wait_tick();
        int k = 0;
        while (!bus.tick && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.tick) chk("tick_timeout", 0, 1);
    endtask

    task automatic wait_level(input int ch, input int val, input int budget);
        int k = 0;
        while (int'(bus.level[ch*LW +: LW]) != val && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("wait_level%0d_eq%0d", ch, val), int'(bus.level[ch*LW +: LW]), val);
    endtask

    initial begin
        int nt;
        bus.decay_period = '0;
        bus.recover_en   = '0;
        bus.bump         = '0;
        bus.load_en      = 1'b0;
        bus.load_level   = '0;
        bus.freeze       = 1'b0;
        bus.revive       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_level", int'(bus.level), 'o555);
        chk("rst_mood", int'(bus.mood), 0);
        chk("rst_low", int'(bus.low), 0);
        chk("rst_tick", int'(bus.tick), 0);

        // periods {2,3,0}, release at cycle 0
        bus.decay_period = {16'd0, 16'd3, 16'd2};
        rst = 1'b1;
        repeat (7) @(negedge clk);
        chk("c7_tick", int'(bus.tick), 1);
        chk("c7_lvl0", int'(bus.level[2:0]), 5);
        @(negedge clk);
        chk("c8_lvl0", int'(bus.level[2:0]), 4);
        chk("c8_mood", int'(bus.mood), 0);
        @(negedge clk);
        chk("c9_mood", int'(bus.mood), 1);
        repeat (2) @(negedge clk);
        chk("c11_lvl1", int'(bus.level[5:3]), 5);
        @(negedge clk);
        chk("c12_lvl1", int'(bus.level[5:3]), 4);
        chk("c12_lvl2", int'(bus.level[8:6]), 5);

        // ch0 period 1 runs down to DEATH
        bus.decay_period = {16'd0, 16'd0, 16'd1};
        wait_level(0, 2, 40);
        chk("low0_at2", int'(bus.low), 3'b001);
        chk("idx_at2", int'(bus.need_idx), 0);
        @(negedge clk);
        chk("mood_needy", int'(bus.mood), 2);
        wait_level(0, 0, 40);
        @(negedge clk);
        chk("mood_death", int'(bus.mood), 4);
        bus.decay_period = '0;
        bus.bump = 3'b001;
        @(negedge clk);
        bus.bump = '0;
        @(negedge clk);
        chk("dead_bump_lvl0", int'(bus.level[2:0]), 0);
        chk("dead_mood", int'(bus.mood), 4);
        bus.revive = 1'b1;
        @(negedge clk);
        bus.revive = 1'b0;
        chk("revive_level", int'(bus.level), 'o555);
        chk("revive_mood_n1", int'(bus.mood), 4);
        @(negedge clk);
        chk("revive_mood_n2", int'(bus.mood), 0);

        // ch1 recovers 4 -> 5 and saturates
        bus.decay_period = {16'd0, 16'd1, 16'd0};
        bus.recover_en   = 3'b010;
        bus.load_level   = {3'd5, 3'd4, 3'd5};
        bus.load_en = 1'b1;
        @(negedge clk);
        bus.load_en = 1'b0;
        chk("load_lvl1", int'(bus.level[5:3]), 4);
        wait_level(1, 5, 20);
        repeat (12) @(negedge clk);
        chk("recover_sat", int'(bus.level[5:3]), 5);

        // bump coincident with a decrement step, period 2
        bus.recover_en   = '0;
        bus.decay_period = {16'd0, 16'd0, 16'd2};
        bus.load_level   = {3'd5, 3'd5, 3'd3};
        bus.load_en = 1'b1;
        @(negedge clk);
        bus.load_en = 1'b0;
        wait_tick();
        @(negedge clk);
        wait_tick();
        bus.bump = 3'b001;
        @(negedge clk);
        bus.bump = '0;
        chk("bump_step_lvl0", int'(bus.level[2:0]), 4);
        wait_tick();
        @(negedge clk);
        chk("timer_restart_hold", int'(bus.level[2:0]), 4);
        wait_tick();
        @(negedge clk);
        chk("timer_restart_step", int'(bus.level[2:0]), 3);

        // clamped load, then load together with revive
        bus.decay_period = '0;
        bus.load_level   = {3'd2, 3'd2, 3'd7};
        bus.load_en = 1'b1;
        @(negedge clk);
        bus.load_en = 1'b0;
        chk("load_clamp", int'(bus.level), 'b010_010_101);
        chk("load_low", int'(bus.low), 3'b110);
        chk("load_idx", int'(bus.need_idx), 1);
        @(negedge clk);
        chk("load_sad", int'(bus.mood), 3);
        bus.load_level = '0;
        bus.load_en = 1'b1;
        bus.revive  = 1'b1;
        @(negedge clk);
        bus.load_en = 1'b0;
        bus.revive  = 1'b0;
        chk("revive_wins", int'(bus.level), 'o555);
        @(negedge clk);
        chk("revive_wins_mood", int'(bus.mood), 0);

        // freeze for 20 cycles with period 1
        bus.decay_period = {16'd1, 16'd1, 16'd1};
        bus.freeze = 1'b1;
        nt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.tick) nt++;
        end
        chk("freeze_ticks", nt, 5);
        chk("freeze_level", int'(bus.level), 'o555);
        bus.freeze = 1'b0;
        wait_tick();
        @(negedge clk);
        chk("unfreeze_step", int'(bus.level), 'o444);

        // reset mid-period clears timers
        bus.decay_period = {16'd0, 16'd0, 16'd2};
        wait_tick();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_level", int'(bus.level), 'o555);
        rst = 1'b1;
        repeat (7) @(negedge clk);
        chk("midrst_c7", int'(bus.level[2:0]), 5);
        @(negedge clk);
        chk("midrst_c8", int'(bus.level[2:0]), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pet_need_engine.md
# pet_need_engine

Parametrised need-level engine for the virtual-pet control unit. It keeps CHANNELS independent need levels, such as energy, hunger and entertainment. Each level decays or recovers on its own runtime-programmable period, accepts feed/test pulses and bulk loads, and derives a registered mood state. It replaces the fixed three-counter update logic inside the central FSM. The behaviour FSM consumes `mood`, `low` and `need_idx` instead of re-decoding raw levels.

## Interface
Parameters:
- CHANNELS, 3: number of need channels (≥1).
- LEVEL_W, 3: bits per level.
- LEVEL_MAX, 5: full level; must be < 2^LEVEL_W.
- LOW_THRESH, 2: a level ≤ LOW_THRESH is "low".
- TICK_DIV, 50000: clk cycles per base tick (1 ms at 50 MHz).
- PER_W, 16: bits per channel period, counted in ticks.
- IDX_W: max(1, $clog2(CHANNELS)).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- decay_period  in  CHANNELS*PER_W  per-channel step period in ticks; 0 disables the channel's timer.
- recover_en  in  CHANNELS  level-sensitive; 1 means steps increment instead of decrement (sleep/play).
- bump  in  CHANNELS  one-cycle pulse; +1 to that channel (feed).
- load_en  in  1  one-cycle pulse; load all levels (test mode).
- load_level  in  CHANNELS*LEVEL_W  values applied on load_en.
- freeze  in  1  holds all channel timers and suppresses steps.
- revive  in  1  one-cycle pulse; refill all channels and leave DEATH.
- level  out  CHANNELS*LEVEL_W  current levels; channel i occupies bits [i*LEVEL_W +: LEVEL_W].
- low  out  CHANNELS  level_i ≤ LOW_THRESH.
- empty  out  CHANNELS  level_i == 0.
- mood  out  3  0 IDLE, 1 NEUTRAL, 2 NEEDY, 3 SAD, 4 DEATH.
- need_idx  out  IDX_W  lowest-index channel with low=1; 0 if none.
- tick  out  1  one-cycle base-tick pulse.

## Operation
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - `tick`=1 in the cycle the count equals TICK_DIV-1.
  - Free-running; freeze does not stop it.
- Channel timer t_i (PER_W bits):
  - On each tick with freeze=0 and period_i≠0: if t_i ≥ period_i-1, a step event fires and t_i←0; otherwise t_i←t_i+1.
  - The ≥ compare makes a runtime period decrease fire on the next tick.
  - period_i=0 holds t_i at 0 and produces no steps.
- Step event: recover_en_i=1 gives level_i+1, saturating at LEVEL_MAX. Otherwise level_i-1, saturating at 0.
- Per-cycle update priority, highest first:
  1. revive: all levels ← LEVEL_MAX, all timers ← 0.
  2. load_en: level_i ← min(load_level_i, LEVEL_MAX), all timers ← 0.
  3. In DEATH, nothing else changes.
  4. bump_i: level_i+1, saturating. A coincident step on the same channel is discarded, but its timer still restarts.
  5. Step event.
- Mood FSM:
  - Registered; evaluated every cycle from the registered levels.
  - Decode precedence is DEATH > SAD > NEEDY > IDLE > NEUTRAL:
    - DEATH: any empty.
    - SAD: popcount(low) ≥ 2.
    - NEEDY: exactly one low.
    - IDLE: all levels == LEVEL_MAX.
    - NEUTRAL: otherwise.
  - DEATH is sticky. It is left only on the cycle after revive or load_en, re-decoding from the new levels.
- `low`, `empty` and `need_idx` are combinational decodes of the level registers.

## Timing
- Reset values (async assert, sync release):
  - level = LEVEL_MAX on all channels.
  - timers 0, prescaler 0.
  - tick 0, mood IDLE, need_idx 0, low 0, empty 0.
- Latencies:
  - Level updates 1 cycle after bump/load/revive, or after the tick that produces a step.
  - low/empty/need_idx follow the level with 0 extra cycles.
  - mood follows the level with 1 extra cycle.
- Boundary conditions:
  - Saturation at 0 and LEVEL_MAX: no wrap-around.
  - Bump in the same cycle as a decrement step: level rises by 1 (step discarded).
  - load_en together with revive: revive wins.
  - Reset asserted mid-period: timers clear; the first step occurs a full period after release.
  - freeze=1 across a tick: t_i is unchanged. Bump and load still apply.

## Test plan
Configuration for all scenarios: CHANNELS=3, LEVEL_MAX=5, LOW_THRESH=2, TICK_DIV=4.
- Reset, then periods {2,3,0} with recover_en=0:
  - Ch0 drops 5→4 at the 2nd tick (cycle 8) and ch1 at the 3rd tick.
  - Ch2 stays at 5.
  - mood goes IDLE→NEUTRAL one cycle after the first drop.
- Ch0 with period 1 runs down to 0:
  - low[0]=1 when level reaches 2; mood=NEEDY, need_idx=0.
  - On reaching 0, mood=DEATH.
  - Further bumps are ignored and the level stays at 0.
  - revive → all levels 5 and mood IDLE two cycles later.
- Ch1 at 4 with recover_en[1]=1 and period 1: level reaches 5 and stays 5 on further ticks (saturation).
- Ch0 at 3 with bump[0] pulsed on the exact cycle a decrement step fires: level becomes 4, and t_0 restarts at 0.
- load_en with load_level {7,2,2}: levels become {5,2,2}, low=3'b110, mood=SAD, need_idx=1.
- freeze=1 for 20 cycles with period 1: levels unchanged and tick still pulses every 4 cycles. After freeze drops, a step occurs on the next tick.
